ssram: RTL and testbench
========================

SSRAM -- requirements
Module: ssram

Interface
REQ-001 Parameters: none.
REQ-002 The design SHALL use one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  system clock; all logic on rising edge; sram_sclk = clk/2.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 address  input  19  byte address, latched on accept.
REQ-006 valid  input  1  transaction request.
REQ-007 ready  output  1  high when idle, initialised and able to accept.
REQ-008 write  input  1  1=write, 0=read; latched on accept.
REQ-009 wdata  input  8  write data; latched on accept.
REQ-010 rdata  output  8  read data; holds value until the next read completes.
REQ-011 rdata_en  output  1  one-clk pulse; rdata valid in that cycle.
REQ-012 sram_sclk  output  1  serial SRAM clock; idles low (SPI mode 0).
REQ-013 sram_cs_n  output  1  serial SRAM chip select, active low.
REQ-014 sram_sio  inout  4  SRAM SIO[3:0]; high-Z whenever not driven.

Function
REQ-015 Serial slot: sclk low for 1 clk, then high for 1 clk; controller changes sio only while sclk is low; the SRAM samples on sclk rise.
REQ-016 Init after reset release: cs_n high for 2 clk, then cs_n low and send EQIO 0x38 MSB-first on sio[0], 1 bit per slot, 8 slots, with sio[3:1] driven 1; then cs_n high; ready rises 2 clk after cs_n rises.
REQ-017 After init, all frames are quad (SQI), 1 nibble per slot, high nibble first.
REQ-018 Accept: valid=1 and ready=1 in the same clk (cycle T); latch address/write/wdata; ready=0 from T+1 until the frame ends; valid while ready=0 is ignored.
REQ-019 Write frame: cmd 0x02 (2 nibbles), 24-bit address {5'b0,address} (6 nibbles), wdata (2 nibbles); 10 slots.
REQ-020 Read frame: cmd 0x03 (2 nibbles), 24-bit address (6 nibbles), 2 dummy nibbles, 2 data nibbles; 12 slots.
REQ-021 Timing: cs_n falls at T+1 with nibble 0 driven; slot k sclk rises at T+2+2k.
REQ-022 Read turnaround: controller releases sio (high-Z) from the start of dummy slot 8 to frame end; each data nibble is sampled on the clk edge that raises sclk (T+22 high nibble, T+24 low nibble).
REQ-023 Write end: cs_n=1 and sclk=0 at T+21; ready=1 at T+22.
REQ-024 Read end: cs_n=1 at T+25; rdata updated and rdata_en=1 at T+25 for exactly one clk; ready=1 at T+26.
REQ-025 cs_n stays high for at least 2 clk between frames; an accept in the first cycle ready=1 gives back-to-back frames with exactly 2 clk of cs_n high.
REQ-026 States: INIT_WAIT, INIT_CMD, IDLE, CMD, ADDR, DUMMY, DATA, END; 5-bit slot counter, 1-bit phase (sclk) bit.
REQ-027 sclk never toggles while cs_n=1; no partial slot occurs at any frame edge.

Reset
REQ-028 While reset=1: sram_sclk=0, sram_cs_n=1, sram_sio=Z, ready=0, rdata=0x00, rdata_en=0, FSM=INIT_WAIT.
REQ-029 Reset mid-frame aborts at once: cs_n=1, sio=Z, no rdata_en. Init (EQIO) reruns after reset release, and the pending request is discarded.

Verification
REQ-030 Reset release -> cs_n low, sio[0] bits 0,0,1,1,1,0,0,0 on 8 sclk rises, then cs_n high, ready=1.
REQ-031 write(100, 0x7B) -> nibbles 0,2,0,0,0,0,6,4,7,B on 10 sclk rises; ready=1 at T+22; rdata_en stays 0.
REQ-032 write(200, 0xEA) then write(300, 0x22) back-to-back -> nibbles 0,2,0,0,0,0,C,8,E,A and 0,2,0,0,0,1,2,C,2,2; cs_n high exactly 2 clk between frames.
REQ-033 read(100) with the model driving 7 then B after the dummy slots -> cmd nibbles 0,3, address 0,0,0,0,6,4; sio high-Z from slot 8; rdata=0x7B with a 1-clk rdata_en at T+25.
REQ-034 valid held high during a frame -> no second frame until ready=1; exactly one frame per accept.
REQ-035 reset asserted during ADDR of a read -> cs_n=1 immediately, no rdata_en; EQIO resent after release, then a normal read succeeds.

Source files
------------

// File: rtl/ssram_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ssram_if : request/response bus of the serial SRAM controller    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface ssram_if;
   logic [18:0] address;
   logic        valid;
   logic        ready;
   logic        write;
   logic [7:0]  wdata;
   logic [7:0]  rdata;
   logic        rdata_en;

   modport master (
      output address, valid, write, wdata,
      input  ready, rdata, rdata_en
   );

   modport slave (
      input  address, valid, write, wdata,
      output ready, rdata, rdata_en
   );
endinterface
`default_nettype wire

// File: rtl/ssram.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ssram : single-byte read/write controller for a quad-SPI serial  |
// |         SRAM; switches the part to SQI mode after every reset.   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module ssram (
   input  wire        clk,
   input  wire        reset,
   ssram_if.slave     bus,
   output wire        sram_sclk,
   output wire        sram_cs_n,
   inout  wire  [3:0] sram_sio
);

   localparam logic [7:0] c_EQIO      = 8'h38;
   localparam logic [7:0] c_CMD_WRITE = 8'h02;
   localparam logic [7:0] c_CMD_READ  = 8'h03;

   typedef enum logic [2:0] {
      ST_INIT_WAIT = 3'd0,
      ST_INIT_CMD  = 3'd1,
      ST_IDLE      = 3'd2,
      ST_CMD       = 3'd3,
      ST_ADDR      = 3'd4,
      ST_DUMMY     = 3'd5,
      ST_DATA      = 3'd6,
      ST_END       = 3'd7
   } state_t;

   state_t      r_state,     w_state_nx;
   logic [4:0]  r_slot,      w_slot_nx;
   logic        r_sclk,      w_sclk_nx;
   logic        r_cs_n,      w_cs_n_nx;
   logic        r_sio_oe,    w_sio_oe_nx;
   logic [3:0]  r_sio_out,   w_sio_out_nx;
   logic        r_ready,     w_ready_nx;
   logic [7:0]  r_rdata,     w_rdata_nx;
   logic        r_rdata_en,  w_rdata_en_nx;
   logic [18:0] r_addr,      w_addr_nx;
   logic        r_wr,        w_wr_nx;
   logic [7:0]  r_wdata,     w_wdata_nx;
   logic [7:0]  r_rx,        w_rx_nx;

   logic [4:0]  w_slot_inc;
   logic [3:0]  w_frame_nib;

   assign w_slot_inc = r_slot + 5'd1;

   // Nibble for the slot about to start; slot 0 is driven directly on accept.
   always_comb begin
      w_frame_nib = 4'h0;
      case (w_slot_inc)
         5'd1:    w_frame_nib = r_wr ? c_CMD_WRITE[3:0] : c_CMD_READ[3:0];
         5'd3:    w_frame_nib = {1'b0, r_addr[18:16]};
         5'd4:    w_frame_nib = r_addr[15:12];
         5'd5:    w_frame_nib = r_addr[11:8];
         5'd6:    w_frame_nib = r_addr[7:4];
         5'd7:    w_frame_nib = r_addr[3:0];
         5'd8:    w_frame_nib = r_wdata[7:4];
         5'd9:    w_frame_nib = r_wdata[3:0];
         default: w_frame_nib = 4'h0;
      endcase
   end

   always_comb begin
      w_state_nx    = r_state;
      w_slot_nx     = r_slot;
      w_sclk_nx     = 1'b0;
      w_cs_n_nx     = r_cs_n;
      w_sio_oe_nx   = r_sio_oe;
      w_sio_out_nx  = r_sio_out;
      w_ready_nx    = 1'b0;
      w_rdata_nx    = r_rdata;
      w_rdata_en_nx = 1'b0;
      w_addr_nx     = r_addr;
      w_wr_nx       = r_wr;
      w_wdata_nx    = r_wdata;
      w_rx_nx       = r_rx;

      case (r_state)
         ST_INIT_WAIT: begin
            w_cs_n_nx   = 1'b1;
            w_sio_oe_nx = 1'b0;
            if (r_slot == 5'd1) begin
               w_state_nx   = ST_INIT_CMD;
               w_slot_nx    = 5'd0;
               w_cs_n_nx    = 1'b0;
               w_sio_oe_nx  = 1'b1;
               w_sio_out_nx = {3'b111, c_EQIO[7]};
            end else begin
               w_slot_nx = w_slot_inc;
            end
         end

         ST_IDLE: begin
            w_ready_nx = 1'b1;
            if (bus.valid && r_ready) begin
               w_state_nx   = ST_CMD;
               w_slot_nx    = 5'd0;
               w_cs_n_nx    = 1'b0;
               w_sio_oe_nx  = 1'b1;
               w_sio_out_nx = c_CMD_WRITE[7:4];
               w_ready_nx   = 1'b0;
               w_addr_nx    = bus.address;
               w_wr_nx      = bus.write;
               w_wdata_nx   = bus.wdata;
            end
         end

         // Slot counter doubles as the cs_n-high dwell: init waits 2 clk, frames 1.
         ST_END: begin
            if (r_slot == 5'd1) begin
               w_state_nx = ST_IDLE;
               w_slot_nx  = 5'd0;
               w_ready_nx = 1'b1;
            end else begin
               w_slot_nx = w_slot_inc;
            end
         end

         default: begin
            if (!r_sclk) begin
               w_sclk_nx = 1'b1;
               if (r_state == ST_DATA && !r_wr)
                  w_rx_nx = {r_rx[3:0], sram_sio};
            end else begin
               w_slot_nx    = w_slot_inc;
               w_sio_out_nx = (r_state == ST_INIT_CMD) ?
                              {3'b111, c_EQIO[3'd7 - w_slot_inc[2:0]]} : w_frame_nib;
               case (r_state)
                  ST_INIT_CMD: begin
                     if (r_slot == 5'd7) begin
                        w_state_nx  = ST_END;
                        w_slot_nx   = 5'd0;
                        w_cs_n_nx   = 1'b1;
                        w_sio_oe_nx = 1'b0;
                     end
                  end
                  ST_CMD: begin
                     if (r_slot == 5'd1)
                        w_state_nx = ST_ADDR;
                  end
                  ST_ADDR: begin
                     if (r_slot == 5'd7) begin
                        if (r_wr) begin
                           w_state_nx = ST_DATA;
                        end else begin
                           w_state_nx  = ST_DUMMY;
                           w_sio_oe_nx = 1'b0;
                        end
                     end
                  end
                  ST_DUMMY: begin
                     if (r_slot == 5'd9)
                        w_state_nx = ST_DATA;
                  end
                  ST_DATA: begin
                     if (r_slot == (r_wr ? 5'd9 : 5'd11)) begin
                        w_state_nx  = ST_END;
                        w_slot_nx   = 5'd1;
                        w_cs_n_nx   = 1'b1;
                        w_sio_oe_nx = 1'b0;
                        if (!r_wr) begin
                           w_rdata_nx    = r_rx;
                           w_rdata_en_nx = 1'b1;
                        end
                     end
                  end
                  default: ;
               endcase
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_INIT_WAIT;
         r_slot     <= 5'd0;
         r_sclk     <= 1'b0;
         r_cs_n     <= 1'b1;
         r_sio_oe   <= 1'b0;
         r_sio_out  <= 4'h0;
         r_ready    <= 1'b0;
         r_rdata    <= 8'h00;
         r_rdata_en <= 1'b0;
         r_addr     <= 19'd0;
         r_wr       <= 1'b0;
         r_wdata    <= 8'h00;
         r_rx       <= 8'h00;
      end else begin
         r_state    <= w_state_nx;
         r_slot     <= w_slot_nx;
         r_sclk     <= w_sclk_nx;
         r_cs_n     <= w_cs_n_nx;
         r_sio_oe   <= w_sio_oe_nx;
         r_sio_out  <= w_sio_out_nx;
         r_ready    <= w_ready_nx;
         r_rdata    <= w_rdata_nx;
         r_rdata_en <= w_rdata_en_nx;
         r_addr     <= w_addr_nx;
         r_wr       <= w_wr_nx;
         r_wdata    <= w_wdata_nx;
         r_rx       <= w_rx_nx;
      end
   end

   assign sram_sclk    = r_sclk;
   assign sram_cs_n    = r_cs_n;
   assign sram_sio     = r_sio_oe ? r_sio_out : 4'bzzzz;
   assign bus.ready    = r_ready;
   assign bus.rdata    = r_rdata;
   assign bus.rdata_en = r_rdata_en;

endmodule
`default_nettype wire

// File: tb/tb_ssram.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_ssram : bench for ssram with a behavioural SQI SRAM model      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_ssram;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   wire        sram_sclk;
   wire        sram_cs_n;
   wire  [3:0] sram_sio;

   ssram_if bus ();

   ssram dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .sram_sclk (sram_sclk),
      .sram_cs_n (sram_cs_n),
      .sram_sio  (sram_sio)
   );

   always #5 clk = ~clk;

   // Undriven SIO lines read as 1, so a released bus shows up as 4'hF.
   pullup (sram_sio[0]);
   pullup (sram_sio[1]);
   pullup (sram_sio[2]);
   pullup (sram_sio[3]);

   logic       m_oe  = 1'b0;
   logic [3:0] m_out = 4'h0;
   assign sram_sio = m_oe ? m_out : 4'bzzzz;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Serial SRAM model: records every nibble seen on a sclk rise per frame,
   // stores write frames, and answers read frames after two dummy slots.
   logic [3:0]  cur [0:15];
   int          cur_len = 0;
   logic [47:0] frame_bits [0:31];
   int          frame_len  [0:31];
   int          nframes = 0;
   logic [7:0]  mem     [int];
   logic [7:0]  ref_mem [int];
   logic [18:0] m_addr;
   logic [7:0]  m_byte;

   always @(posedge sram_sclk or posedge sram_cs_n) begin
      if (sram_cs_n === 1'b0) begin
         if (cur_len < 16) cur[cur_len] = sram_sio;
         cur_len++;
      end else if (cur_len > 0) begin
         frame_bits[nframes % 32] = 48'h0;
         for (int i = 0; i < cur_len && i < 12; i++)
            frame_bits[nframes % 32] = {frame_bits[nframes % 32][43:0], cur[i]};
         frame_len[nframes % 32] = cur_len;
         if (cur_len == 10 && cur[0] == 4'h0 && cur[1] == 4'h2)
            mem[int'({cur[3][2:0], cur[4], cur[5], cur[6], cur[7]})] = {cur[8], cur[9]};
         nframes++;
         cur_len = 0;
      end
   end

   always @(negedge sram_sclk or posedge sram_cs_n) begin
      if (sram_cs_n !== 1'b0) begin
         m_oe = 1'b0;
      end else if (cur[0] == 4'h0 && cur[1] == 4'h3 && (cur_len == 10 || cur_len == 11)) begin
         m_addr = {cur[3][2:0], cur[4], cur[5], cur[6], cur[7]};
         m_byte = mem.exists(int'(m_addr)) ? mem[int'(m_addr)] : 8'hFF;
         m_oe   = 1'b1;
         m_out  = (cur_len == 10) ? m_byte[7:4] : m_byte[3:0];
      end
   end

   // Waits for init after reset release: one EQIO frame, ready 2 clk after cs_n rises.
   task automatic wait_init(input string tag);
      int   f0, lim, rise, rdy;
      logic prev_cs;
      f0 = nframes; lim = 0; rise = -100; rdy = -1; prev_cs = 1'b1;
      while (lim < 100 && rdy < 0) begin
         @(posedge clk); #1;
         if (prev_cs === 1'b0 && sram_cs_n === 1'b1 && rise < 0) rise = lim;
         if (bus.ready === 1'b1) rdy = lim;
         prev_cs = sram_cs_n;
         lim++;
      end
      check({tag, "/ready_after_cs_rise"}, 64'(rdy - rise), 64'd2);
      check({tag, "/eqio_frames"}, 64'(nframes - f0), 64'd1);
      check({tag, "/eqio_len"}, 64'(frame_len[f0 % 32]), 64'd8);
      check({tag, "/eqio_bits"}, frame_bits[f0 % 32], 48'hEEFFFEEE);
   endtask

   task automatic txn(input bit wr, input logic [18:0] a, input logic [7:0] d,
                      input bit hold, input string tag);
      int          nslots, tend, lim, f0;
      bit          sclk_ok, cs_ok, rdy_ok, en_ok;
      logic [7:0]  exp_rd;
      logic [47:0] exp_bits;
      lim = 0;
      while (bus.ready !== 1'b1 && lim < 100) begin
         @(posedge clk); #1;
         lim++;
      end
      check({tag, "/ready_wait"}, bus.ready, 1);
      exp_rd      = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 8'hFF;
      bus.valid   = 1'b1;
      bus.write   = wr;
      bus.address = a;
      bus.wdata   = d;
      f0      = nframes;
      nslots  = wr ? 10 : 12;
      tend    = 2 * nslots + 1;
      sclk_ok = 1; cs_ok = 1; rdy_ok = 1; en_ok = 1;
      for (int n = 1; n <= tend + 1; n++) begin
         @(posedge clk); #1;
         if (!hold) begin
            bus.valid   = 1'b0;
            bus.address = 19'($urandom);
            bus.wdata   = 8'($urandom);
            bus.write   = 1'($urandom);
         end
         if (n <= 2 * nslots) begin
            if (sram_sclk !== ((n % 2) == 0)) sclk_ok = 0;
            if (sram_cs_n !== 1'b0) cs_ok = 0;
         end
         if (n <= tend && bus.ready !== 1'b0) rdy_ok = 0;
         if (n != tend && bus.rdata_en !== 1'b0) en_ok = 0;
         if (n == tend) begin
            check({tag, "/cs_n_end"}, sram_cs_n, 1);
            check({tag, "/sclk_end"}, sram_sclk, 0);
            check({tag, "/rdata_en_end"}, bus.rdata_en, wr ? 0 : 1);
            if (!wr) check({tag, "/rdata"}, bus.rdata, exp_rd);
         end
      end
      check({tag, "/ready_up"}, bus.ready, 1);
      check({tag, "/cs_n_gap"}, sram_cs_n, 1);
      bus.valid = 1'b0;
      check({tag, "/sclk_pattern"}, sclk_ok, 1);
      check({tag, "/cs_n_low_in_frame"}, cs_ok, 1);
      check({tag, "/ready_low_in_frame"}, rdy_ok, 1);
      check({tag, "/rdata_en_pulse"}, en_ok, 1);
      check({tag, "/frames_per_accept"}, 64'(nframes - f0), 64'd1);
      check({tag, "/frame_len"}, 64'(frame_len[f0 % 32]), 64'(nslots));
      if (wr) exp_bits = 48'({8'h02, 5'b0, a, d});
      else    exp_bits = {8'h03, 5'b0, a, 8'hFF, exp_rd};
      check({tag, "/frame_nibbles"}, frame_bits[f0 % 32], exp_bits);
      if (wr) ref_mem[int'(a)] = d;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [18:0] ra;
      logic [7:0]  rd;
      int          lim;
      bit          en_seen;
      bus.valid = 1'b0; bus.write = 1'b0; bus.address = 19'd0; bus.wdata = 8'h00;

      repeat (3) @(posedge clk);
      #1;
      check("rst/cs_n", sram_cs_n, 1);
      check("rst/sclk", sram_sclk, 0);
      check("rst/sio_z", sram_sio, 4'hF);
      check("rst/ready", bus.ready, 0);
      check("rst/rdata", bus.rdata, 8'h00);
      check("rst/rdata_en", bus.rdata_en, 0);
      @(negedge clk); reset = 1'b0;
      wait_init("init");

      txn(1'b1, 19'd100, 8'h7B, 1'b0, "wr100");
      txn(1'b1, 19'd200, 8'hEA, 1'b0, "wr200");
      txn(1'b1, 19'd300, 8'h22, 1'b0, "wr300_b2b");
      txn(1'b0, 19'd100, 8'h00, 1'b0, "rd100");
      txn(1'b0, 19'd200, 8'h00, 1'b1, "rd200_hold");
      txn(1'b1, 19'd5,   8'h55, 1'b0, "wr5");
      check("rdata_hold_after_write", bus.rdata, 8'hEA);
      txn(1'b1, 19'h7FFFF, 8'hFF, 1'b0, "wr_max");
      txn(1'b1, 19'h00000, 8'h00, 1'b0, "wr_zero");
      txn(1'b0, 19'h7FFFF, 8'h00, 1'b0, "rd_max");
      txn(1'b0, 19'h00000, 8'h00, 1'b0, "rd_zero");

      for (int i = 0; i < 4; i++) begin
         ra = 19'($urandom);
         rd = 8'($urandom);
         txn(1'b1, ra, rd, 1'b0, "wr_rand");
         txn(1'b0, ra, 8'h00, 1'b0, "rd_rand");
      end

      // Abort a read while its address is on the bus.
      lim = 0;
      while (bus.ready !== 1'b1 && lim < 100) begin
         @(posedge clk); #1;
         lim++;
      end
      check("abort/ready_wait", bus.ready, 1);
      bus.valid = 1'b1; bus.write = 1'b0; bus.address = 19'd300;
      @(posedge clk); #1;
      bus.valid = 1'b0;
      repeat (6) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      check("abort/cs_n", sram_cs_n, 1);
      check("abort/sclk", sram_sclk, 0);
      check("abort/sio_z", sram_sio, 4'hF);
      check("abort/ready", bus.ready, 0);
      check("abort/rdata", bus.rdata, 8'h00);
      en_seen = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (bus.rdata_en !== 1'b0) en_seen = 1;
      end
      check("abort/no_rdata_en", en_seen, 0);
      @(negedge clk); reset = 1'b0;
      wait_init("reinit");
      txn(1'b0, 19'd300, 8'h00, 1'b0, "rd300_after_reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
